// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ==== uart_rx_fifo : configurable-frame UART receiver, 3-sample vote, word FIFO ==== Rev 1.0 ====
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_parity_err,
    output logic                 o_frame_err,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_overrun,
    output logic                 o_break,
    output logic                 o_busy
);

    localparam int          MID      = (CLKS_PER_BIT - 1) / 2;
    localparam logic [15:0] CNT_S0   = 16'(MID - 1);
    localparam logic [15:0] CNT_S1   = 16'(MID);
    localparam logic [15:0] CNT_VOTE = 16'(MID + 1);
    localparam logic [15:0] CNT_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [3:0]  LAST_IDX = 4'(DATA_BITS - 1);
    localparam int          AW       = $clog2(FIFO_DEPTH);
    localparam int          WW       = DATA_BITS + 2;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    state_t               state, state_n;
    logic                 rx_meta, rx;
    logic [15:0]          cnt, cnt_n;
    logic [3:0]           idx, idx_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic                 smp0, smp0_n, smp1, smp1_n;
    logic                 pbit, pbit_n, perr, perr_n, ferr, ferr_n;
    logic                 do_push, brk_n, ovr_n;
    logic [WW-1:0]        push_word;
    logic                 vote;

    logic [WW-1:0]        mem [FIFO_DEPTH];
    logic [AW-1:0]        wptr, rptr;
    logic [AW:0]          count;
    logic                 full, pop;
    logic [WW-1:0]        head;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx      <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rx      <= rx_meta;
        end
    end

    assign vote = (smp0 & smp1) | (smp0 & rx) | (smp1 & rx);
    assign full = (count == (AW+1)'(FIFO_DEPTH));
    assign pop  = o_valid & i_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            idx       <= '0;
            shreg     <= '0;
            smp0      <= 1'b1;
            smp1      <= 1'b1;
            pbit      <= 1'b0;
            perr      <= 1'b0;
            ferr      <= 1'b0;
            o_break   <= 1'b0;
            o_overrun <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            idx       <= idx_n;
            shreg     <= shreg_n;
            smp0      <= smp0_n;
            smp1      <= smp1_n;
            pbit      <= pbit_n;
            perr      <= perr_n;
            ferr      <= ferr_n;
            o_break   <= brk_n;
            o_overrun <= ovr_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt + 16'd1;
        idx_n     = idx;
        shreg_n   = shreg;
        smp0_n    = (cnt == CNT_S0) ? rx : smp0;
        smp1_n    = (cnt == CNT_S1) ? rx : smp1;
        pbit_n    = pbit;
        perr_n    = perr;
        ferr_n    = ferr;
        do_push   = 1'b0;
        brk_n     = 1'b0;
        ovr_n     = 1'b0;
        push_word = {shreg, perr, ferr | ~vote};
        case (state)
            S_IDLE: begin
                cnt_n  = '0;
                idx_n  = '0;
                pbit_n = 1'b0;
                perr_n = 1'b0;
                ferr_n = 1'b0;
                if (!rx) state_n = S_START;
            end
            S_START: begin
                if (cnt == CNT_VOTE && vote) begin
                    cnt_n   = '0;
                    state_n = S_IDLE;
                end else if (cnt == CNT_LAST) begin
                    cnt_n   = '0;
                    state_n = S_DATA;
                end
            end
            S_DATA: begin
                if (cnt == CNT_VOTE) begin
                    for (int i = 0; i < DATA_BITS; i++) begin
                        if (idx == 4'(i)) shreg_n[i] = vote;
                    end
                end
                if (cnt == CNT_LAST) begin
                    cnt_n = '0;
                    if (idx == LAST_IDX) begin
                        idx_n   = '0;
                        state_n = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        idx_n = idx + 4'd1;
                    end
                end
            end
            S_PARITY: begin
                if (cnt == CNT_VOTE) begin
                    pbit_n = vote;
                    perr_n = (PARITY == 1) ? (^shreg ^ vote) : ~(^shreg ^ vote);
                end
                if (cnt == CNT_LAST) begin
                    cnt_n   = '0;
                    state_n = S_STOP;
                end
            end
            S_STOP: begin
                // The final stop bit closes at its vote point so the next start edge is not missed.
                if (cnt == CNT_VOTE && (STOP_BITS == 1 || idx == 4'd1)) begin
                    cnt_n   = '0;
                    state_n = S_IDLE;
                    if (shreg == '0 && !pbit && !vote) begin
                        brk_n   = 1'b1;
                        state_n = S_BREAK;
                    end else if (full && !pop) begin
                        ovr_n = 1'b1;
                    end else begin
                        do_push = 1'b1;
                    end
                end else begin
                    if (cnt == CNT_VOTE && !vote) ferr_n = 1'b1;
                    if (cnt == CNT_LAST) begin
                        cnt_n = '0;
                        idx_n = 4'd1;
                    end
                end
            end
            S_BREAK: begin
                cnt_n = '0;
                if (rx) state_n = S_IDLE;
            end
            default: begin
                cnt_n   = '0;
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wptr] <= push_word;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (pop)     rptr <= rptr + AW'(1);
            case ({do_push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign head         = mem[rptr];
    assign o_valid      = (count != '0);
    assign o_data       = o_valid ? head[WW-1:2] : '0;
    assign o_parity_err = o_valid & head[1];
    assign o_frame_err  = o_valid & head[0];
    assign o_busy       = (state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ==== tb_uart_rx_fifo : scoreboard bench for 8-N-1 and 7-E-2 receiver instances ==== Rev 1.0 ====
module tb_uart_rx_fifo;

    localparam int CPB = 16;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset_n;
    logic       rx8, rdy8, perr8, ferr8, valid8, ovr8, brk8, busy8;
    logic [7:0] data8;
    logic       rx7, rdy7, perr7, ferr7, valid7, ovr7, brk7, busy7;
    logic [6:0] data7;

    int n_cmp = 0;
    int n_bad = 0;
    logic [9:0] exp8[$], got8[$];
    logic [8:0] exp7[$], got7[$];
    int ovr_cnt8 = 0, brk_cnt8 = 0, ovr_cnt7 = 0, brk_cnt7 = 0;

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut8 (
        .clock(clock), .reset_n(reset_n), .i_rx(rx8), .o_data(data8), .o_parity_err(perr8),
        .o_frame_err(ferr8), .o_valid(valid8), .i_ready(rdy8), .o_overrun(ovr8), .o_break(brk8),
        .o_busy(busy8));

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) dut7 (
        .clock(clock), .reset_n(reset_n), .i_rx(rx7), .o_data(data7), .o_parity_err(perr7),
        .o_frame_err(ferr7), .o_valid(valid7), .i_ready(rdy7), .o_overrun(ovr7), .o_break(brk7),
        .o_busy(busy7));

    // Records every accepted head word and counts event pulses, sampled mid low-phase.
    always @(negedge clock) begin
        #2;
        if (valid8 && rdy8) got8.push_back({data8, perr8, ferr8});
        if (valid7 && rdy7) got7.push_back({data7, perr7, ferr7});
        if (ovr8) ovr_cnt8++;
        if (brk8) brk_cnt8++;
        if (ovr7) ovr_cnt7++;
        if (brk7) brk_cnt7++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_line(input int which, input logic v);
        if (which == 0) rx8 = v;
        else            rx7 = v;
    endtask

    task automatic send_frame(input int which, input logic [8:0] d, input int nbits, input int par,
                              input int nstop, input logic flip_par, input logic stop2_low,
                              input logic [8:0] glitch);
        logic bits[16];
        logic gl[16];
        logic p;
        int   n;
        n = 0;
        p = 1'b0;
        for (int k = 0; k < 16; k++) gl[k] = 1'b0;
        bits[n] = 1'b0; n++;
        for (int i = 0; i < nbits; i++) begin
            bits[n] = d[i];
            gl[n]   = glitch[i];
            p       = p ^ d[i];
            n++;
        end
        if (par != 0) begin
            if (par == 2) p = ~p;
            bits[n] = p ^ flip_par; n++;
        end
        bits[n] = 1'b1; n++;
        if (nstop == 2) begin
            bits[n] = ~stop2_low; n++;
        end
        for (int k = 0; k < n; k++) begin
            for (int c = 0; c < CPB; c++) begin
                set_line(which, (gl[k] && c == 10) ? ~bits[k] : bits[k]);
                @(negedge clock);
            end
        end
        set_line(which, 1'b1);
    endtask

    task automatic test_reset;
        reset_n = 1'b0; rx8 = 1'b1; rx7 = 1'b1; rdy8 = 1'b0; rdy7 = 1'b0;
        repeat (4) @(negedge clock);
        n_cmp++; if (valid8 !== 1'b0 || busy8 !== 1'b0) begin n_bad++;
            $display("FAIL reset_valid_busy8: got %b%b expected 00", valid8, busy8); end
        n_cmp++; if (data8 !== 8'h00 || perr8 !== 1'b0 || ferr8 !== 1'b0) begin n_bad++;
            $display("FAIL reset_data8: got %h/%b/%b expected 00/0/0", data8, perr8, ferr8); end
        n_cmp++; if (ovr8 !== 1'b0 || brk8 !== 1'b0) begin n_bad++;
            $display("FAIL reset_pulses8: got %b%b expected 00", ovr8, brk8); end
        n_cmp++; if (valid7 !== 1'b0 || busy7 !== 1'b0 || data7 !== 7'h00) begin n_bad++;
            $display("FAIL reset_dut7: got %b%b %h expected 00 00", valid7, busy7, data7); end
        reset_n = 1'b1;
        repeat (4) @(negedge clock);
        n_cmp++; if (valid8 !== 1'b0 || busy8 !== 1'b0) begin n_bad++;
            $display("FAIL post_reset_idle8: got %b%b expected 00", valid8, busy8); end
    endtask

    task automatic test_basic;
        logic [9:0] g, e;
        rdy8 = 1'b1;
        exp8.push_back({8'hA5, 2'b00});
        send_frame(0, 9'h0A5, 8, 0, 1, 1'b0, 1'b0, 9'h0);
        repeat (2 * CPB) @(negedge clock);
        n_cmp++; if (got8.size() != 1) begin n_bad++;
            $display("FAIL basic_one_word: got %0d words expected 1", got8.size()); end
        exp8.push_back({8'h96, 2'b00});
        send_frame(0, 9'h096, 8, 0, 1, 1'b0, 1'b0, 9'h0);
        repeat (2 * CPB) @(negedge clock);
        n_cmp++; if (got8.size() != exp8.size()) begin n_bad++;
            $display("FAIL basic_count: got %0d words expected %0d", got8.size(), exp8.size()); end
        while (got8.size() > 0 && exp8.size() > 0) begin
            g = got8.pop_front(); e = exp8.pop_front();
            n_cmp++; if (g !== e) begin n_bad++;
                $display("FAIL basic_word: got %h expected %h", g, e); end
        end
        got8.delete(); exp8.delete();
    endtask

    task automatic test_parity_frame;
        logic [8:0] g, e;
        int o0, b0;
        o0 = ovr_cnt7; b0 = brk_cnt7;
        rdy7 = 1'b1;
        exp7.push_back({7'h55, 2'b10});
        send_frame(1, 9'h055, 7, 1, 2, 1'b1, 1'b0, 9'h0);
        repeat (2 * CPB) @(negedge clock);
        exp7.push_back({7'h2A, 2'b01});
        send_frame(1, 9'h02A, 7, 1, 2, 1'b0, 1'b1, 9'h0);
        repeat (2 * CPB) @(negedge clock);
        exp7.push_back({7'h13, 2'b00});
        send_frame(1, 9'h013, 7, 1, 2, 1'b0, 1'b0, 9'h0);
        repeat (2 * CPB) @(negedge clock);
        n_cmp++; if (got7.size() != exp7.size()) begin n_bad++;
            $display("FAIL parity_count: got %0d words expected %0d", got7.size(), exp7.size()); end
        while (got7.size() > 0 && exp7.size() > 0) begin
            g = got7.pop_front(); e = exp7.pop_front();
            n_cmp++; if (g !== e) begin n_bad++;
                $display("FAIL parity_word: got %h expected %h", g, e); end
        end
        n_cmp++; if (ovr_cnt7 != o0 || brk_cnt7 != b0) begin n_bad++;
            $display("FAIL parity_no_events: got ovr %0d brk %0d expected 0 0", ovr_cnt7 - o0, brk_cnt7 - b0); end
        got7.delete(); exp7.delete();
    endtask

    task automatic test_overrun;
        logic [9:0] g, e;
        int o0;
        o0 = ovr_cnt8;
        rdy8 = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) exp8.push_back({8'(i), 2'b00});
            send_frame(0, 9'(i), 8, 0, 1, 1'b0, 1'b0, 9'h0);
            repeat (CPB) @(negedge clock);
        end
        n_cmp++; if (ovr_cnt8 - o0 != 1) begin n_bad++;
            $display("FAIL overrun_pulses: got %0d expected 1", ovr_cnt8 - o0); end
        n_cmp++; if (valid8 !== 1'b1 || data8 !== 8'h01) begin n_bad++;
            $display("FAIL overrun_head_hold: got %b/%h expected 1/01", valid8, data8); end
        rdy8 = 1'b1;
        repeat (12) @(negedge clock);
        rdy8 = 1'b0;
        repeat (2) @(negedge clock);
        n_cmp++; if (got8.size() != 4) begin n_bad++;
            $display("FAIL overrun_drain_count: got %0d expected 4", got8.size()); end
        while (got8.size() > 0 && exp8.size() > 0) begin
            g = got8.pop_front(); e = exp8.pop_front();
            n_cmp++; if (g !== e) begin n_bad++;
                $display("FAIL overrun_word: got %h expected %h", g, e); end
        end
        n_cmp++; if (valid8 !== 1'b0) begin n_bad++;
            $display("FAIL overrun_empty: got valid %b expected 0", valid8); end
        got8.delete(); exp8.delete();
    endtask

    task automatic test_glitch;
        logic [9:0] g, e;
        rdy8 = 1'b1;
        exp8.push_back({8'h5A, 2'b00});
        send_frame(0, 9'h05A, 8, 0, 1, 1'b0, 1'b0, 9'h009);
        repeat (2 * CPB) @(negedge clock);
        rx8 = 1'b0;
        repeat (3) @(negedge clock);
        rx8 = 1'b1;
        repeat (3) @(negedge clock);
        n_cmp++; if (busy8 !== 1'b1) begin n_bad++;
            $display("FAIL glitch_start_seen: got busy %b expected 1", busy8); end
        repeat (2 * CPB) @(negedge clock);
        n_cmp++; if (busy8 !== 1'b0 || valid8 !== 1'b0) begin n_bad++;
            $display("FAIL glitch_false_start: got busy %b valid %b expected 0 0", busy8, valid8); end
        n_cmp++; if (got8.size() != exp8.size()) begin n_bad++;
            $display("FAIL glitch_count: got %0d expected %0d", got8.size(), exp8.size()); end
        while (got8.size() > 0 && exp8.size() > 0) begin
            g = got8.pop_front(); e = exp8.pop_front();
            n_cmp++; if (g !== e) begin n_bad++;
                $display("FAIL glitch_word: got %h expected %h", g, e); end
        end
        got8.delete(); exp8.delete();
    endtask

    task automatic test_break;
        logic [9:0] g, e;
        int b0;
        b0 = brk_cnt8;
        rdy8 = 1'b1;
        rx8 = 1'b0;
        repeat (3 * 10 * CPB) @(negedge clock);
        n_cmp++; if (busy8 !== 1'b1) begin n_bad++;
            $display("FAIL break_busy: got %b expected 1", busy8); end
        n_cmp++; if (brk_cnt8 - b0 != 1) begin n_bad++;
            $display("FAIL break_pulses: got %0d expected 1", brk_cnt8 - b0); end
        rx8 = 1'b1;
        repeat (2 * CPB) @(negedge clock);
        n_cmp++; if (busy8 !== 1'b0) begin n_bad++;
            $display("FAIL break_exit: got busy %b expected 0", busy8); end
        exp8.push_back({8'h3C, 2'b00});
        send_frame(0, 9'h03C, 8, 0, 1, 1'b0, 1'b0, 9'h0);
        repeat (2 * CPB) @(negedge clock);
        n_cmp++; if (got8.size() != exp8.size()) begin n_bad++;
            $display("FAIL break_count: got %0d expected %0d", got8.size(), exp8.size()); end
        while (got8.size() > 0 && exp8.size() > 0) begin
            g = got8.pop_front(); e = exp8.pop_front();
            n_cmp++; if (g !== e) begin n_bad++;
                $display("FAIL break_word: got %h expected %h", g, e); end
        end
        n_cmp++; if (brk_cnt8 - b0 != 1) begin n_bad++;
            $display("FAIL break_single: got %0d expected 1", brk_cnt8 - b0); end
        got8.delete(); exp8.delete();
    endtask

    task automatic test_reset_midframe;
        logic [9:0] g, e;
        rdy8 = 1'b0;
        send_frame(0, 9'h011, 8, 0, 1, 1'b0, 1'b0, 9'h0);
        repeat (CPB) @(negedge clock);
        send_frame(0, 9'h022, 8, 0, 1, 1'b0, 1'b0, 9'h0);
        repeat (CPB) @(negedge clock);
        n_cmp++; if (valid8 !== 1'b1) begin n_bad++;
            $display("FAIL midreset_queued: got valid %b expected 1", valid8); end
        fork
            send_frame(0, 9'h033, 8, 0, 1, 1'b0, 1'b0, 9'h0);
            begin
                repeat (5 * CPB) @(negedge clock);
                reset_n = 1'b0;
                #1;
                n_cmp++; if (valid8 !== 1'b0 || busy8 !== 1'b0) begin n_bad++;
                    $display("FAIL midreset_clear: got valid %b busy %b expected 0 0", valid8, busy8); end
            end
        join
        @(negedge clock);
        reset_n = 1'b1;
        repeat (2 * CPB) @(negedge clock);
        rdy8 = 1'b1;
        exp8.push_back({8'h7E, 2'b00});
        send_frame(0, 9'h07E, 8, 0, 1, 1'b0, 1'b0, 9'h0);
        repeat (2 * CPB) @(negedge clock);
        n_cmp++; if (got8.size() != exp8.size()) begin n_bad++;
            $display("FAIL midreset_count: got %0d expected %0d", got8.size(), exp8.size()); end
        while (got8.size() > 0 && exp8.size() > 0) begin
            g = got8.pop_front(); e = exp8.pop_front();
            n_cmp++; if (g !== e) begin n_bad++;
                $display("FAIL midreset_word: got %h expected %h", g, e); end
        end
        got8.delete(); exp8.delete();
    endtask

    initial begin
        reset_n = 1'b0; rx8 = 1'b1; rx7 = 1'b1; rdy8 = 1'b0; rdy7 = 1'b0;
        @(negedge clock);
        test_reset();
        test_basic();
        test_parity_frame();
        test_overrun();
        test_glitch();
        test_break();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
